// File: rtl/clk_period_meter.sv
// Measures the period and high time of an asynchronous tick signal in clk cycles,
// with a valid/ack handshake, sticky overrun and a timeout for a stalled input.
module clk_period_meter #(
  parameter int CNT_W     = 26,
  parameter int MAX_COUNT = 50_000_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sig_in,
  input  logic             enable,
  input  logic             meas_ack,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  output logic             overrun,
  output logic             timeout
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  // The count held on the cycle before the next increment would reach MAX_COUNT.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_COUNT - 1);

  state_t           state_q, state_d;
  logic [2:0]       sync_q, sync_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] hi_cnt_q, hi_cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_time_q, high_time_d;
  logic             meas_valid_q, meas_valid_d;
  logic             overrun_q, overrun_d;
  logic             timeout_q, timeout_d;

  logic rise;
  logic fall;

  // sync_q[0] and sync_q[1] form the synchronizer; sync_q[2] is the edge-history flop.
  assign sync_d = {sync_q[1:0], sig_in};
  assign rise   = sync_q[1] & ~sync_q[2];
  assign fall   = ~sync_q[1] & sync_q[2];

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d      = state_q;
    cnt_d        = cnt_q;
    hi_cnt_d     = hi_cnt_q;
    period_d     = period_q;
    high_time_d  = high_time_q;
    meas_valid_d = meas_valid_q;
    overrun_d    = overrun_q;
    timeout_d    = timeout_q;

    if (!enable) begin
      state_d      = IDLE;
      cnt_d        = '0;
      hi_cnt_d     = '0;
      meas_valid_d = 1'b0;
      overrun_d    = 1'b0;
      timeout_d    = 1'b0;
    end else begin
      // An acknowledge retires the result; a capture below on the same edge wins.
      if (meas_valid_q && meas_ack) begin
        meas_valid_d = 1'b0;
      end

      unique case (state_q)
        IDLE: begin
          cnt_d   = '0;
          state_d = ARM;
        end
        ARM: begin
          if (rise) begin
            cnt_d   = CNT_ONE;
            state_d = MEASURE;
          end
        end
        MEASURE: begin
          if (rise) begin
            period_d     = cnt_q;
            high_time_d  = hi_cnt_q;
            meas_valid_d = 1'b1;
            timeout_d    = 1'b0;
            cnt_d        = CNT_ONE;
            if (meas_valid_q && !meas_ack) begin
              overrun_d = 1'b1;
            end
          end else begin
            if (fall) begin
              hi_cnt_d = cnt_q;
            end
            if (cnt_q == CNT_LAST) begin
              timeout_d = 1'b1;
              cnt_d     = '0;
              state_d   = ARM;
            end else begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      sync_q       <= '0;
      cnt_q        <= '0;
      hi_cnt_q     <= '0;
      period_q     <= '0;
      high_time_q  <= '0;
      meas_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync_q       <= sync_d;
      cnt_q        <= cnt_d;
      hi_cnt_q     <= hi_cnt_d;
      period_q     <= period_d;
      high_time_q  <= high_time_d;
      meas_valid_q <= meas_valid_d;
      overrun_q    <= overrun_d;
      timeout_q    <= timeout_d;
    end
  end

  assign period     = period_q;
  assign high_time  = high_time_q;
  assign meas_valid = meas_valid_q;
  assign overrun    = overrun_q;
  assign timeout    = timeout_q;

endmodule
